// File: rtl/dsp_sys_arr_pkg.sv
// Shared types for the systolic array datapath.
// Words are single-precision floats carried as raw bits.
package dsp_sys_arr_pkg;

  localparam int SNGL_FLT_SIZE = 32;

  typedef logic [SNGL_FLT_SIZE-1:0] word_t;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FULL   = 2'd1,
    ACTIVE = 2'd2
  } bank_state_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } feed_state_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/feeder_lane.sv
// One edge lane: word pointer, pass counter and valid.
// Finished once the pass counter reaches the latched repeat count.
module feeder_lane
  import dsp_sys_arr_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int REP_W = 4,
  parameter int PW    = 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr_i,
  input  logic             run_i,
  input  logic             en_i,
  input  logic             ready_i,
  input  logic [REP_W-1:0] rep_i,
  output logic             valid_o,
  output logic [PW-1:0]    ptr_o,
  output logic             fin_o
);

  logic [PW-1:0]    p_q, p_d;
  logic [REP_W-1:0] c_q, c_d;

  assign fin_o   = (c_q == rep_i);
  assign valid_o = run_i & en_i & ~fin_o;
  assign ptr_o   = p_q;

  always_comb begin
    p_d = p_q;
    c_d = c_q;
    if (clr_i) begin
      p_d = '0;
      c_d = '0;
    end else if (valid_o && ready_i) begin
      if (p_q == PW'(DEPTH-1)) begin
        p_d = '0;
        c_d = c_q + 1'b1;
      end else begin
        p_d = p_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      p_q <= '0;
      c_q <= '0;
    end else begin
      p_q <= p_d;
      c_q <= c_d;
    end
  end

endmodule

// File: rtl/operand_feeder.sv
// Ping-pong operand banks feeding the systolic array edge lanes.
// One bank fills from the load stream while the other replays.
module operand_feeder
  import dsp_sys_arr_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 2,
  parameter int BW    = 2,
  parameter int SKEW  = 1,
  parameter int REP_W = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  word_t [BW-1:0]        ld_dat,
  input  logic [REP_W-1:0]      cfg_repeat,
  output logic [LANES-1:0]      out_valid,
  input  logic [LANES-1:0]      out_ready,
  output word_t [LANES-1:0]     out_dat,
  output logic                  busy,
  output logic                  done
);

  localparam int NW = LANES * DEPTH;
  localparam int AW = clog2_min1(NW);
  localparam int PW = clog2_min1(DEPTH);
  localparam int SW = clog2_min1(LANES);
  localparam int BI = clog2_min1(BW);

  word_t            mem_q [2][NW];
  bank_state_t      bank_q [2];
  bank_state_t      bank_d [2];
  feed_state_t      st_q, st_d;
  logic             wb_q, wb_d, rb_q, rb_d;
  logic [AW-1:0]    wp_q, wp_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [SW-1:0]    sk_q, sk_d;

  logic [LANES-1:0] en, fin;
  logic [PW-1:0]    ptr [LANES];
  logic             ld_fire, fill_done;
  logic             run, start, all_fin;

  assign ld_ready  = (bank_q[wb_q] == EMPTY);
  assign ld_fire   = ld_valid & ld_ready;
  assign fill_done = ld_fire & (wp_q == AW'(NW-BW));
  assign run       = (st_q == RUN);
  assign all_fin   = &fin;
  assign busy      = run;
  assign done      = run & all_fin;

  // Bypass the FULL flag so a bank can start draining right behind its last beat
  assign start = (st_q == IDLE) &
                 ((bank_q[rb_q] == FULL) |
                  (fill_done & (wb_q == rb_q)));

  always_ff @(posedge clk) begin
    if (ld_fire) begin
      for (int b = 0; b < BW; b++) begin
        mem_q[wb_q][wp_q + AW'(b)] <= ld_dat[BI'(b)];
      end
    end
  end

  always_comb begin
    st_d   = st_q;
    bank_d = bank_q;
    wb_d   = wb_q;
    rb_d   = rb_q;
    wp_d   = wp_q;
    rep_d  = rep_q;
    sk_d   = sk_q;
    if (ld_fire) begin
      wp_d = fill_done ? '0 : wp_q + AW'(BW);
    end
    if (fill_done) begin
      bank_d[wb_q] = FULL;
      wb_d         = ~wb_q;
    end
    unique case (st_q)
      IDLE: begin
        if (start) begin
          st_d         = RUN;
          bank_d[rb_q] = ACTIVE;
          rep_d        = (cfg_repeat == '0) ? REP_W'(1) : cfg_repeat;
          sk_d         = '0;
        end
      end
      RUN: begin
        if (all_fin) begin
          st_d         = IDLE;
          bank_d[rb_q] = EMPTY;
          rb_d         = ~rb_q;
        end else if (sk_q != SW'(LANES-1)) begin
          sk_d = sk_q + 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st_q      <= IDLE;
      bank_q[0] <= EMPTY;
      bank_q[1] <= EMPTY;
      wb_q      <= 1'b0;
      rb_q      <= 1'b0;
      wp_q      <= '0;
      rep_q     <= '0;
      sk_q      <= '0;
    end else begin
      st_q   <= st_d;
      bank_q <= bank_d;
      wb_q   <= wb_d;
      rb_q   <= rb_d;
      wp_q   <= wp_d;
      rep_q  <= rep_d;
      sk_q   <= sk_d;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign en[l] = (SKEW == 0) || (sk_q >= SW'(l));

    feeder_lane #(
      .DEPTH (DEPTH),
      .REP_W (REP_W),
      .PW    (PW)
    ) u_lane (
      .clk     (clk),
      .nrst    (nrst),
      .clr_i   (start),
      .run_i   (run),
      .en_i    (en[l]),
      .ready_i (out_ready[l]),
      .rep_i   (rep_q),
      .valid_o (out_valid[l]),
      .ptr_o   (ptr[l]),
      .fin_o   (fin[l])
    );

    assign out_dat[l] = run ?
      mem_q[rb_q][AW'(l*DEPTH) + AW'(ptr[l])] : '0;
  end

endmodule

// File: tb/tb_operand_feeder.sv
// Scoreboard bench for operand_feeder: skewed and unskewed instances.
// Expected lane words are queued at stimulus time, popped on handshake.
module tb_operand_feeder;
  import dsp_sys_arr_pkg::*;

  localparam int L = 2;

  localparam word_t F1  = 32'h3F800000;
  localparam word_t F2  = 32'h40000000;
  localparam word_t F3  = 32'h40400000;
  localparam word_t F4  = 32'h40800000;
  localparam word_t F5  = 32'h40A00000;
  localparam word_t F6  = 32'h40C00000;
  localparam word_t F7  = 32'h40E00000;
  localparam word_t F8  = 32'h41000000;
  localparam word_t F9  = 32'h41100000;
  localparam word_t F10 = 32'h41200000;
  localparam word_t F11 = 32'h41300000;
  localparam word_t F12 = 32'h41400000;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic            a_ld_valid, a_ld_ready, a_busy, a_done;
  word_t [1:0]     a_ld_dat;
  logic [3:0]      a_rep;
  logic [L-1:0]    a_ov, a_or;
  word_t [L-1:0]   a_od;

  logic            b_ld_valid, b_ld_ready, b_busy, b_done;
  word_t [1:0]     b_ld_dat;
  logic [3:0]      b_rep;
  logic [L-1:0]    b_ov, b_or;
  word_t [L-1:0]   b_od;

  operand_feeder #(
    .LANES(L), .DEPTH(2), .BW(2), .SKEW(1), .REP_W(4)
  ) u_a (
    .clk(clk), .nrst(nrst),
    .ld_valid(a_ld_valid), .ld_ready(a_ld_ready), .ld_dat(a_ld_dat),
    .cfg_repeat(a_rep),
    .out_valid(a_ov), .out_ready(a_or), .out_dat(a_od),
    .busy(a_busy), .done(a_done)
  );

  operand_feeder #(
    .LANES(L), .DEPTH(2), .BW(2), .SKEW(0), .REP_W(4)
  ) u_b (
    .clk(clk), .nrst(nrst),
    .ld_valid(b_ld_valid), .ld_ready(b_ld_ready), .ld_dat(b_ld_dat),
    .cfg_repeat(b_rep),
    .out_valid(b_ov), .out_ready(b_or), .out_dat(b_od),
    .busy(b_busy), .done(b_done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  word_t qa [L][$];
  word_t qb [L][$];
  int a_done_cnt = 0, a_last_done = -1;
  int b_done_cnt = 0, b_last_done = -1;

  always @(negedge clk) begin
    word_t e;
    for (int l = 0; l < L; l++) begin
      if (a_ov[l] && a_or[l]) begin
        n_tests++;
        if (qa[l].size() == 0) begin
          n_fail++;
          $display("FAIL a_lane%0d_extra: got %h, none expected", l, a_od[l]);
        end else begin
          e = qa[l].pop_front();
          if (a_od[l] !== e) begin
            n_fail++;
            $display("FAIL a_lane%0d_data: got %h expected %h", l, a_od[l], e);
          end
        end
      end
      if (b_ov[l] && b_or[l]) begin
        n_tests++;
        if (qb[l].size() == 0) begin
          n_fail++;
          $display("FAIL b_lane%0d_extra: got %h, none expected", l, b_od[l]);
        end else begin
          e = qb[l].pop_front();
          if (b_od[l] !== e) begin
            n_fail++;
            $display("FAIL b_lane%0d_data: got %h expected %h", l, b_od[l], e);
          end
        end
      end
    end
    if (a_done) begin
      a_done_cnt++;
      a_last_done = cyc;
    end
    if (b_done) begin
      b_done_cnt++;
      b_last_done = cyc;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input bit sel, input word_t w0, input word_t w1,
                      input word_t w2, input word_t w3, input int rep);
    for (int r = 0; r < rep; r++) begin
      if (sel) begin
        qb[0].push_back(w0); qb[0].push_back(w1);
        qb[1].push_back(w2); qb[1].push_back(w3);
      end else begin
        qa[0].push_back(w0); qa[0].push_back(w1);
        qa[1].push_back(w2); qa[1].push_back(w3);
      end
    end
  endtask

  // Call at posedge+1; returns at posedge+1 of the cycle after the last beat.
  task automatic load(input bit sel, input word_t w0, input word_t w1,
                      input word_t w2, input word_t w3, output int t);
    word_t v [4];
    int k;
    v = '{w0, w1, w2, w3};
    t = 0;
    for (int bt = 0; bt < 2; bt++) begin
      if (sel) begin
        b_ld_valid = 1'b1;
        b_ld_dat = {v[2*bt+1], v[2*bt]};
      end else begin
        a_ld_valid = 1'b1;
        a_ld_dat = {v[2*bt+1], v[2*bt]};
      end
      k = 0;
      @(negedge clk);
      while (!(sel ? b_ld_ready : a_ld_ready) && k < 100) begin
        @(negedge clk);
        k++;
      end
      if (k >= 100) begin
        n_tests++;
        n_fail++;
        $display("FAIL load_timeout: ld_ready got 0 expected 1");
      end
      t = cyc;
      @(posedge clk);
      #1;
    end
    a_ld_valid = 1'b0;
    b_ld_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int x);
    @(negedge clk);
    while (cyc < x) @(negedge clk);
  endtask

  task automatic drive_at(input int x);
    while (cyc < x) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input bit sel, input int target);
    int k;
    k = 0;
    while ((sel ? b_done_cnt : a_done_cnt) < target && k < 500) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("done_reached", sel ? b_done_cnt : a_done_cnt, target);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_ld_ready"}, a_ld_ready, 1);
    chk({tag, "_out_valid"}, a_ov, 0);
    chk({tag, "_out_dat"}, {a_od[1], a_od[0]}, 0);
    chk({tag, "_busy"}, a_busy, 0);
    chk({tag, "_done"}, a_done, 0);
  endtask

  int t, tb2, base;

  initial begin
    a_ld_valid = 0; a_ld_dat = '0; a_rep = 4'd1; a_or = '1;
    b_ld_valid = 0; b_ld_dat = '0; b_rep = 4'd1; b_or = '1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_a("rst");
    chk("rst_b_out_valid", b_ov, 0);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // basic drain, skewed
    push(0, F1, F2, F3, F4, 1);
    load(0, F1, F2, F3, F4, t);
    wait_cyc(t+1);
    chk("basic_busy", a_busy, 1);
    chk("basic_v_t1", a_ov, 2'b01);
    chk("basic_d0_t1", a_od[0], F1);
    wait_cyc(t+2);
    chk("basic_v_t2", a_ov, 2'b11);
    wait_cyc(t+3);
    chk("basic_v_t3", a_ov, 2'b10);
    wait_cyc(t+4);
    chk("basic_done_t4", a_done, 1);
    chk("basic_v_t4", a_ov, 2'b00);
    wait_cyc(t+5);
    chk("basic_done_t5", a_done, 0);
    chk("basic_busy_t5", a_busy, 0);
    @(posedge clk);
    #1;
    chk("basic_done_cnt", a_done_cnt, 1);
    chk("basic_done_cyc", a_last_done, t+4);

    // repeat 3, then repeat 0 treated as 1
    a_rep = 4'd3;
    push(0, F1, F2, F3, F4, 3);
    load(0, F1, F2, F3, F4, t);
    wait_done(0, 2);
    chk("rep3_done_cyc", a_last_done, t+8);
    repeat (4) @(posedge clk);
    #1;
    chk("rep3_single_done", a_done_cnt, 2);
    a_rep = 4'd0;
    push(0, F5, F6, F7, F8, 1);
    load(0, F5, F6, F7, F8, t);
    wait_done(0, 3);
    chk("rep0_done_cyc", a_last_done, t+4);

    // backpressure on lane 1
    a_rep = 4'd1;
    push(0, F1, F2, F3, F4, 1);
    load(0, F1, F2, F3, F4, t);
    drive_at(t+3);
    a_or = 2'b01;
    for (int k = 3; k <= 7; k++) begin
      wait_cyc(t+k);
      chk("bp_v1_held", a_ov[1], 1);
      chk("bp_d1_stable", a_od[1], F4);
      if (k == 3) chk("bp_lane0_done", a_ov[0], 0);
    end
    drive_at(t+8);
    a_or = 2'b11;
    wait_done(0, 4);
    chk("bp_done_cyc", a_last_done, t+9);

    // ping-pong with a third set queued behind
    a_rep = 4'd3;
    push(0, F1, F2, F3, F4, 3);
    push(0, F5, F6, F7, F8, 3);
    push(0, F9, F10, F11, F12, 3);
    load(0, F1, F2, F3, F4, t);
    load(0, F5, F6, F7, F8, tb2);
    chk("pp_b_back2back", tb2, t+2);
    for (int k = 3; k <= 8; k++) begin
      wait_cyc(t+k);
      chk("pp_ld_ready_low", a_ld_ready, 0);
    end
    wait_cyc(t+9);
    chk("pp_ld_ready_high", a_ld_ready, 1);
    chk("pp_idle_gap", a_busy, 0);
    wait_cyc(t+10);
    chk("pp_first_done", a_last_done, t+8);
    chk("pp_b_start_v", a_ov, 2'b01);
    chk("pp_b_start_d", a_od[0], F5);
    drive_at(t+11);
    load(0, F9, F10, F11, F12, tb2);
    wait_done(0, 7);

    // unskewed instance
    push(1, F1, F2, F3, F4, 1);
    load(1, F1, F2, F3, F4, t);
    wait_cyc(t+1);
    chk("ns_v_t1", b_ov, 2'b11);
    chk("ns_d1_t1", b_od[1], F3);
    wait_cyc(t+2);
    chk("ns_v_t2", b_ov, 2'b11);
    wait_cyc(t+3);
    chk("ns_done_t3", b_done, 1);
    chk("ns_v_t3", b_ov, 2'b00);
    @(posedge clk);
    #1;
    chk("ns_done_cnt", b_done_cnt, 1);

    // reset mid-run with both banks in use
    push(0, F1, F2, F3, F4, 3);
    load(0, F1, F2, F3, F4, t);
    load(0, F5, F6, F7, F8, tb2);
    drive_at(t+4);
    nrst = 1'b0;
    #1;
    chk_reset_a("midrst");
    for (int l = 0; l < L; l++) qa[l].delete();
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    @(posedge clk);
    #1;
    a_rep = 4'd1;
    base = a_done_cnt;
    push(0, F9, F10, F11, F12, 1);
    load(0, F9, F10, F11, F12, t);
    wait_done(0, base+1);
    chk("postrst_done_cyc", a_last_done, t+4);
    repeat (6) @(posedge clk);
    #1;
    chk("postrst_no_stale", a_done_cnt, base+1);
    chk("postrst_busy", a_busy, 0);

    for (int l = 0; l < L; l++) begin
      chk("a_queue_empty", qa[l].size(), 0);
      chk("b_queue_empty", qb[l].size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
